stop_watch: RTL and testbench
=============================

Name: stop_watch

Overview:
Single-button stopwatch. One push-button cycles a one-hot mode FSM IDLE -> CLEAR -> RUNNING -> IDLE. In RUNNING, a 5-bit seconds counter advances once per second, derived from a 100 Hz system clock. Top-level user-facing block: the raw button comes in, and mode plus elapsed seconds go out to the display logic.

Parameters:
TICKS_PER_SEC, 100, clock cycles per one-second tick (100 Hz clk).
TIME_W, 5, width of time_o.

Ports:
clk  input  1  system clock, 100 Hz nominal, rising-edge active.
nRst_i  input  1  asynchronous active-low reset.
button_i  input  1  raw asynchronous push-button, active high.
state  output  3  one-hot mode: IDLE=3'b100, CLEAR=3'b010, RUNNING=3'b001.
time_o  output  TIME_W  elapsed seconds.

Behaviour:
- Interface fixed: one clock (clk); reset nRst_i is asynchronous, active-low.
- Reset, while nRst_i=0 regardless of button_i:
  - state=IDLE, time_o=0, prescaler=0.
  - Both synchronizer flops and the edge-history flop cleared to 0.
- Button path:
  - 2-flop synchronizer, then rising-edge detector (sync2 & ~prev); produces a 1-cycle press pulse.
  - Press pulse asserts 2 cycles after button_i is first sampled high.
  - state updates on the 3rd rising edge after that first sample.
  - A held button produces exactly one pulse. A new pulse needs button_i low for at least one sampled cycle.
  - A button held through reset release counts as one press after the same latency; state stays IDLE for at least 2 edges after release.
- FSM: advances one step per press pulse: IDLE->CLEAR, CLEAR->RUNNING, RUNNING->IDLE. No other transitions; no pulse means hold.
- CLEAR: time_o forced to 0 and prescaler forced to 0 every cycle.
- RUNNING:
  - Prescaler counts 0..TICKS_PER_SEC-1.
  - When it equals TICKS_PER_SEC-1, it returns to 0 and time_o increments.
  - First increment comes exactly TICKS_PER_SEC cycles after entering RUNNING from CLEAR.
- IDLE: time_o and prescaler hold (pause). IDLE->CLEAR zeroes time. Leaving RUNNING on the tick cycle still applies that tick.
- Wrap: time_o 31 -> 0 (mod 2^TIME_W) unless STOP_WATCH_SATURATE_EN is defined.
- Outputs registered; state is always a legal one-hot value.

Optional Feature:
STOP_WATCH_SATURATE_EN
- Defined: time_o saturates at 2^TIME_W-1 (31) while RUNNING. Prescaler keeps running; CLEAR still zeroes.
- Undefined: time_o wraps 31 -> 0.

Decomposition:
- Package stop_watch_pkg:
  - mode_t enum logic[2:0] {IDLE=3'b100, CLEAR=3'b010, RUNNING=3'b001}.
  - TICKS_PER_SEC and TIME_W default constants.
- One sub-module: button_sync_edge (clk, nRst_i, button_i -> press_o).
  - 2-flop synchronizer plus rising-edge detector, async-reset to 0.
- FSM, prescaler and time counter stay in stop_watch.

Test Plan:
- Reset: hold nRst_i=0 with button_i=1 for 2 cycles -> state=3'b100, time_o=0; one negedge after release -> still 3'b100, time_o=0.
- Mode cycle: after reset, 1-cycle press then wait 5 cycles -> 3'b010; repeat -> 3'b001; repeat -> 3'b100.
- Held button: button_i=1 for 20 cycles from IDLE -> state=3'b010 throughout after latency, no further change; release -> still 3'b010.
- Counting: enter RUNNING from CLEAR -> time_o=0, then 1, 2, 3, 4 sampled at 100-cycle intervals. Increment exactly 100 cycles after RUNNING entry.
- Pause/clear: RUNNING to time_o=3, press -> IDLE, time_o holds 3 for 300 cycles; press -> CLEAR, time_o=0.
- Wrap: run 32 s -> time_o goes 31 -> 0; with STOP_WATCH_SATURATE_EN -> stays 31.

Source files
------------

// File: rtl/stop_watch_pkg.sv
// Shared types and default constants for the single-button stopwatch.
package stop_watch_pkg;

  localparam int unsigned DEF_TICKS_PER_SEC = 100;
  localparam int unsigned DEF_TIME_W        = 5;

  // One-hot mode encoding as seen by the display logic.
  typedef enum logic [2:0] {
    IDLE    = 3'b100,
    CLEAR   = 3'b010,
    RUNNING = 3'b001
  } mode_t;

  // A single press always moves the mode one step around the ring.
  function automatic mode_t next_mode(input mode_t m);
    case (m)
      IDLE:    return CLEAR;
      CLEAR:   return RUNNING;
      default: return IDLE;
    endcase
  endfunction

endpackage

// File: rtl/button_sync_edge.sv
// Two-flop synchronizer for the raw push-button followed by a registered rising-edge pulse.
module button_sync_edge (
  input  logic clk,
  input  logic nRst_i,
  input  logic button_i,
  output logic press_o
);

  logic sync1_q, sync2_q, prev_q, press_q;

  // press_q fires on the second edge after the first high sample, so the mode
  // register consuming it moves on the third edge.
  always_ff @(posedge clk or negedge nRst_i) begin
    if (!nRst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= button_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      press_q <= sync2_q & ~prev_q;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/stop_watch.sv
// Single-button stopwatch: press cycles IDLE -> CLEAR -> RUNNING, seconds counted in RUNNING.
// Define STOP_WATCH_SATURATE_EN to make time_o stick at its maximum instead of wrapping.
module stop_watch
  import stop_watch_pkg::*;
#(
  parameter int unsigned TICKS_PER_SEC = DEF_TICKS_PER_SEC,
  parameter int unsigned TIME_W        = DEF_TIME_W
) (
  input  logic              clk,
  input  logic              nRst_i,
  input  logic              button_i,
  output logic [2:0]        state,
  output logic [TIME_W-1:0] time_o
);

  localparam int unsigned PRESC_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(TICKS_PER_SEC - 1);

  logic               press;
  mode_t              state_q, state_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [TIME_W-1:0]  time_q, time_d;

  button_sync_edge u_button (
    .clk      (clk),
    .nRst_i   (nRst_i),
    .button_i (button_i),
    .press_o  (press)
  );

  always_comb begin
    state_d = press ? next_mode(state_q) : state_q;
    presc_d = presc_q;
    time_d  = time_q;
    // Counting keys off the current mode, so a tick on the cycle RUNNING is left still lands.
    unique case (state_q)
      CLEAR: begin
        presc_d = '0;
        time_d  = '0;
      end
      RUNNING: begin
        if (presc_q == PRESC_MAX) begin
          presc_d = '0;
`ifdef STOP_WATCH_SATURATE_EN
          if (time_q != '1) begin
            time_d = time_q + TIME_W'(1);
          end
`else
          time_d = time_q + TIME_W'(1);
`endif
        end else begin
          presc_d = presc_q + PRESC_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge nRst_i) begin
    if (!nRst_i) begin
      state_q <= IDLE;
      presc_q <= '0;
      time_q  <= '0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      time_q  <= time_d;
    end
  end

  assign state  = state_q;
  assign time_o = time_q;

endmodule

// File: tb/tb_stop_watch.sv
// Self-checking bench for stop_watch: vector table plus cycle-stamped scoreboard.
module tb_stop_watch;

  localparam logic [2:0] S_IDLE = 3'b100;
  localparam logic [2:0] S_CLR  = 3'b010;
  localparam logic [2:0] S_RUN  = 3'b001;

  logic       clk = 1'b0;
  logic       nRst_i;
  logic       button_i;
  logic [2:0] state;
  logic [4:0] time_o;

  stop_watch dut (
    .clk      (clk),
    .nRst_i   (nRst_i),
    .button_i (button_i),
    .state    (state),
    .time_o   (time_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         at;
    logic [2:0] st;
    logic [4:0] tm;
    string      nm;
  } exp_t;

  typedef struct {
    logic       btn;
    int         hold;
    logic       chk;
    logic [2:0] st;
    logic [4:0] tm;
    string      nm;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[9];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string nm, input logic [2:0] est, input logic [4:0] etm);
    total++;
    if (state !== est || time_o !== etm) begin
      bad++;
      $display("FAIL %s @cyc %0d: got state=%b time=%0d, want state=%b time=%0d",
               nm, cyc, state, time_o, est, etm);
    end
  endtask

  task automatic expect_at(input int at, input logic [2:0] st, input logic [4:0] tm,
                           input string nm);
    exp_t e;
    e.at = at;
    e.st = st;
    e.tm = tm;
    e.nm = nm;
    sb.push_back(e);
  endtask

  task automatic press();
    button_i = 1'b1;
    @(negedge clk);
    button_i = 1'b0;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  // Scoreboard: compare each expectation on the falling edge of its cycle.
  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].at <= cyc) begin
      e = sb.pop_front();
      if (e.at < cyc) begin
        total++;
        bad++;
        $display("FAIL %s: sample missed, due cyc %0d now %0d", e.nm, e.at, cyc);
      end else begin
        check(e.nm, e.st, e.tm);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    int c;
    logic [4:0] top_val, tail_val;
`ifdef STOP_WATCH_SATURATE_EN
    top_val  = 5'd31;
    tail_val = 5'd31;
`else
    top_val  = 5'd0;
    tail_val = 5'd1;
`endif

    // Mode-cycle and held-button vectors, starting from IDLE.
    vecs[0] = '{1'b1, 1, 1'b0, S_IDLE, 5'd0, "p1"};
    vecs[1] = '{1'b0, 5, 1'b1, S_CLR,  5'd0, "cycle_clear"};
    vecs[2] = '{1'b1, 1, 1'b0, S_IDLE, 5'd0, "p2"};
    vecs[3] = '{1'b0, 5, 1'b1, S_RUN,  5'd0, "cycle_run"};
    vecs[4] = '{1'b1, 1, 1'b0, S_IDLE, 5'd0, "p3"};
    vecs[5] = '{1'b0, 5, 1'b1, S_IDLE, 5'd0, "cycle_idle"};
    vecs[6] = '{1'b1, 5, 1'b1, S_CLR,  5'd0, "held_early"};
    vecs[7] = '{1'b1, 15, 1'b1, S_CLR, 5'd0, "held_late"};
    vecs[8] = '{1'b0, 5, 1'b1, S_CLR,  5'd0, "held_release"};

    // Reset with button held, then release with button still held.
    nRst_i   = 1'b0;
    button_i = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_state", S_IDLE, 5'd0);
    nRst_i = 1'b1;
    c = cyc;
    expect_at(c + 1, S_IDLE, 5'd0, "rel_idle1");
    expect_at(c + 3, S_IDLE, 5'd0, "rel_idle3");
    expect_at(c + 4, S_CLR,  5'd0, "held_rst_press");
    repeat (6) @(negedge clk);
    button_i = 1'b0;
    repeat (2) @(negedge clk);

    nRst_i = 1'b0;
    @(negedge clk);
    check("rst2_state", S_IDLE, 5'd0);
    nRst_i = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      button_i = vecs[i].btn;
      if (vecs[i].chk) expect_at(cyc + vecs[i].hold, vecs[i].st, vecs[i].tm, vecs[i].nm);
      repeat (vecs[i].hold) @(negedge clk);
    end

    // Counting, pause and clear; RUNNING starts on posedge c+4.
    c = cyc;
    expect_at(c + 3,   S_CLR, 5'd0, "pre_run");
    expect_at(c + 4,   S_RUN, 5'd0, "run_entry");
    expect_at(c + 103, S_RUN, 5'd0, "before_tick1");
    expect_at(c + 104, S_RUN, 5'd1, "tick1");
    expect_at(c + 204, S_RUN, 5'd2, "tick2");
    expect_at(c + 304, S_RUN, 5'd3, "tick3");
    press();
    wait_until(c + 310);
    press();
    expect_at(c + 314, S_IDLE, 5'd3, "pause_enter");
    expect_at(c + 614, S_IDLE, 5'd3, "pause_hold");
    wait_until(c + 620);
    press();
    expect_at(c + 630, S_CLR, 5'd0, "clear_zero");
    wait_until(c + 640);

    // Long run through the top of the range, leaving RUNNING on a tick edge.
    c = cyc;
    press();
    expect_at(c + 404,  S_RUN, 5'd4,    "tick4");
    expect_at(c + 3154, S_RUN, 5'd31,   "reach_max");
    expect_at(c + 3203, S_RUN, 5'd31,   "before_wrap");
    expect_at(c + 3204, S_RUN, top_val, "wrap_edge");
    wait_until(c + 3300);
    press();
    expect_at(c + 3304, S_IDLE, tail_val, "leave_on_tick");
    expect_at(c + 3400, S_IDLE, tail_val, "idle_hold");
    wait_until(c + 3410);

    for (int i = 0; i < 200 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d expectations never sampled, want 0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
